// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 8x8 keypad scanner.
package keypad_pkg;

  localparam int ROWS = 8;
  localparam int COLS = 8;

  typedef enum logic [1:0] {SETTLE, SAMPLE, EMIT} scan_state_t;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
    logic       pressed;
  } key_event_t;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [2:0] lowest_bit(input logic [COLS-1:0] v);
    lowest_bit = '0;
    for (int i = COLS - 1; i >= 0; i--) begin
      if (v[i]) lowest_bit = 3'(i);
    end
  endfunction

endpackage

// File: rtl/keypad_scanner_row_debounce.sv
// Per-row debounce state: a candidate column vector and a saturating
// count of consecutive scans that matched it.
module row_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            sample_en,
  input  logic [2:0]      row,
  input  logic [COLS-1:0] sample,
  output logic            accept,
  output logic [COLS-1:0] cand_next
);

  logic [ROWS-1:0][COLS-1:0] cand_q, cand_d;
  logic [ROWS-1:0][2:0]      cnt_q, cnt_d;
  logic [2:0]                cnt_next;
  logic                      match;

  always_comb begin
    match     = (sample == cand_q[row]);
    cand_next = match ? cand_q[row] : sample;
    if (!match)
      cnt_next = 3'd1;
    else if (cnt_q[row] == 3'(DEBOUNCE_SCANS))
      cnt_next = cnt_q[row];
    else
      cnt_next = cnt_q[row] + 3'd1;
    accept = (cnt_next == 3'(DEBOUNCE_SCANS));

    cand_d = cand_q;
    cnt_d  = cnt_q;
    if (sample_en) begin
      cand_d[row] = cand_next;
      cnt_d[row]  = cnt_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cand_q <= '0;
      cnt_q  <= '0;
    end else begin
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 8x8 active-low key matrix scanner with per-row debounce and a one-deep
// valid/ready event slot toward game logic.
//   state  | meaning
//   SETTLE | row driven, waiting for column lines and synchronizer
//   SAMPLE | one cycle: update debounce for the row, find changed keys
//   EMIT   | push changed keys out one per cycle; stall on backpressure
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [COLS-1:0]           col_sense,
  output logic [ROWS-1:0]           row_drive,
  output logic                      key_valid,
  input  logic                      key_ready,
  output logic [5:0]                key_code,
  output logic                      key_pressed,
  output logic [ROWS-1:0][COLS-1:0] key_map
);

  scan_state_t               state_q, state_d;
  logic [3:0]                settle_q, settle_d;
  logic [2:0]                row_q, row_d;
  logic [COLS-1:0]           pending_q, pending_d;
  logic                      valid_q, valid_d;
  key_event_t                ev_q, ev_d;
  logic [ROWS-1:0][COLS-1:0] key_map_q, key_map_d;
  logic [COLS-1:0]           sync1_q, sync2_q;

  logic                      sample_en;
  logic                      accept;
  logic [COLS-1:0]           cand_next;
  logic [COLS-1:0]           sample_pending;
  logic [2:0]                emit_col;
  logic                      slot_free;
  logic [ROWS-1:0]           row_one;

  row_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
    .clock     (clock),
    .reset     (reset),
    .sample_en (sample_en),
    .row       (row_q),
    .sample    (~sync2_q),
    .accept    (accept),
    .cand_next (cand_next)
  );

  assign emit_col       = lowest_bit(pending_q);
  assign slot_free      = !valid_q || key_ready;
  assign sample_pending = accept ? (cand_next ^ key_map_q[row_q]) : '0;

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    row_d     = row_q;
    pending_d = pending_q;
    valid_d   = valid_q;
    ev_d      = ev_q;
    key_map_d = key_map_q;
    sample_en = 1'b0;

    if (valid_q && key_ready) valid_d = 1'b0;

    case (state_q)
      SETTLE: begin
        if (settle_q == 4'(SETTLE_CYCLES - 1)) begin
          settle_d = '0;
          state_d  = SAMPLE;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      SAMPLE: begin
        sample_en = 1'b1;
        pending_d = sample_pending;
        if (sample_pending != '0) begin
          state_d = EMIT;
        end else begin
          row_d   = row_q + 3'd1;
          state_d = SETTLE;
        end
      end
      EMIT: begin
        if (pending_q != '0) begin
          if (slot_free) begin
            // The key's new state is the opposite of what the map holds.
            valid_d                      = 1'b1;
            ev_d.row                     = row_q;
            ev_d.col                     = emit_col;
            ev_d.pressed                 = ~key_map_q[row_q][emit_col];
            key_map_d[row_q][emit_col]   = ~key_map_q[row_q][emit_col];
            pending_d[emit_col]          = 1'b0;
          end
        end else if (slot_free) begin
          // Leave only once the last event has been taken.
          row_d   = row_q + 3'd1;
          state_d = SETTLE;
        end
      end
      default: state_d = SETTLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= SETTLE;
      settle_q  <= '0;
      row_q     <= '0;
      pending_q <= '0;
      valid_q   <= 1'b0;
      ev_q      <= '0;
      key_map_q <= '0;
      sync1_q   <= '1;
      sync2_q   <= '1;
    end else begin
      state_q   <= state_d;
      settle_q  <= settle_d;
      row_q     <= row_d;
      pending_q <= pending_d;
      valid_q   <= valid_d;
      ev_q      <= ev_d;
      key_map_q <= key_map_d;
      sync1_q   <= col_sense;
      sync2_q   <= sync1_q;
    end
  end

  assign row_one     = {{(ROWS-1){1'b0}}, 1'b1};
  assign row_drive   = ~(row_one << row_q);
  assign key_valid   = valid_q;
  assign key_code    = {ev_q.row, ev_q.col};
  assign key_pressed = ev_q.pressed;
  assign key_map     = key_map_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural key matrix model.
module tb_keypad_scanner;

  logic             clock = 1'b0;
  logic             reset;
  logic [7:0]       col_sense;
  logic [7:0]       row_drive;
  logic             key_valid;
  logic             key_ready;
  logic [5:0]       key_code;
  logic             key_pressed;
  logic [7:0][7:0]  key_map;
  logic [7:0][7:0]  keys;

  int checks = 0;
  int errors = 0;

  keypad_scanner dut (
    .clock       (clock),
    .reset       (reset),
    .col_sense   (col_sense),
    .row_drive   (row_drive),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_code    (key_code),
    .key_pressed (key_pressed),
    .key_map     (key_map)
  );

  always #5 clock = ~clock;

  // Closed keys on the driven (low) row pull their columns low.
  always_comb begin
    col_sense = 8'hFF;
    for (int r = 0; r < 8; r++)
      if (!row_drive[r]) col_sense = col_sense & ~keys[r];
  end

  typedef struct {
    logic [2:0] row;
    logic [2:0] col;
    logic [5:0] code;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wait_event(input int limit, output logic got);
    got = 1'b0;
    for (int i = 0; i < limit; i++) begin
      step();
      if (key_valid) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_cycles(input int n, output int seen);
    seen = 0;
    repeat (n) begin
      step();
      if (key_valid) seen++;
    end
  endtask

  initial begin
    logic       got;
    int         seen, total, bad, lat;
    logic [7:0] one, exp_row, prev;

    vecs[0] = '{3'd7, 3'd7, 6'b111111};
    vecs[1] = '{3'd0, 3'd0, 6'b000000};
    vecs[2] = '{3'd3, 3'd6, 6'b011110};
    vecs[3] = '{3'd5, 3'd2, 6'b101010};
    vecs[4] = '{3'd1, 3'd4, 6'b001100};

    reset = 1'b1; key_ready = 1'b1; keys = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_row_drive", row_drive, 8'hFE);
    check("reset_valid", key_valid, 1'b0);
    check("reset_code", key_code, 6'd0);
    check("reset_map", key_map, 64'd0);

    // Idle scan: 5 cycles per row, no events.
    reset = 1'b0;
    one = 8'b1; bad = 0; seen = 0;
    for (int n = 1; n <= 40; n++) begin
      step();
      exp_row = ~(one << ((n / 5) % 8));
      if (row_drive !== exp_row) bad++;
      if (key_valid) seen++;
    end
    check("scan_order_errs", bad, 0);
    check("scan_no_event", seen, 0);

    // Clean press on (2,5): event on the 3rd row-2 sample.
    keys[2][5] = 1'b1;
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      step();
      if (key_valid) begin
        lat = i;
        break;
      end
    end
    check("press_latency", lat, 96);
    check("press_code", key_code, 6'b010101);
    check("press_dir", key_pressed, 1'b1);
    check("press_map", key_map[2][5], 1'b1);
    run_cycles(80, seen);
    check("press_single", seen, 0);
    keys[2][5] = 1'b0;
    wait_event(200, got);
    check("release_seen", got, 1'b1);
    check("release_code", key_code, 6'b010101);
    check("release_dir", key_pressed, 1'b0);
    check("release_map", key_map[2][5], 1'b0);

    for (int v = 0; v < 5; v++) begin
      keys[vecs[v].row][vecs[v].col] = 1'b1;
      wait_event(200, got);
      check("tbl_press_seen", got, 1'b1);
      check("tbl_press_code", key_code, vecs[v].code);
      check("tbl_press_dir", key_pressed, 1'b1);
      check("tbl_press_map", key_map[vecs[v].row][vecs[v].col], 1'b1);
      keys[vecs[v].row][vecs[v].col] = 1'b0;
      wait_event(200, got);
      check("tbl_rel_seen", got, 1'b1);
      check("tbl_rel_code", key_code, vecs[v].code);
      check("tbl_rel_dir", key_pressed, 1'b0);
      run_cycles(90, seen);
      check("tbl_rel_single", seen, 0);
      check("tbl_rel_map", key_map, 64'd0);
    end

    // Bounce on (4,1), toggled at row-4 scan starts.
    prev = row_drive;
    for (int i = 0; i < 100; i++) begin
      step();
      if (row_drive == 8'hEF && prev != 8'hEF) break;
      prev = row_drive;
    end
    check("bounce_sync_row", row_drive, 8'hEF);
    total = 0;
    keys[4][1] = 1'b1; run_cycles(80, seen);  total += seen;
    keys[4][1] = 1'b0; run_cycles(40, seen);  total += seen;
    keys[4][1] = 1'b1; run_cycles(80, seen);  total += seen;
    keys[4][1] = 1'b0; run_cycles(160, seen); total += seen;
    check("bounce_no_event", total, 0);
    check("bounce_map", key_map, 64'd0);

    // Two keys on row 6: col 0 then col 7, back to back.
    keys[6][0] = 1'b1; keys[6][7] = 1'b1;
    wait_event(200, got);
    check("multi_seen", got, 1'b1);
    check("multi_code0", key_code, 6'b110000);
    check("multi_row0", row_drive, 8'hBF);
    step();
    check("multi_valid1", key_valid, 1'b1);
    check("multi_code1", key_code, 6'b110111);
    check("multi_dir1", key_pressed, 1'b1);
    check("multi_row1", row_drive, 8'hBF);
    check("multi_map", key_map[6], 8'h81);
    keys[6] = 8'h00;
    wait_event(200, got);
    check("multi_rel_code0", key_code, 6'b110000);
    check("multi_rel_dir0", key_pressed, 1'b0);
    step();
    check("multi_rel_code1", key_code, 6'b110111);
    check("multi_rel_valid1", key_valid, 1'b1);
    step();
    check("multi_rel_map", key_map[6], 8'h00);

    // Backpressure on (0,3).
    key_ready = 1'b0;
    keys[0][3] = 1'b1;
    wait_event(200, got);
    check("bp_seen", got, 1'b1);
    check("bp_code", key_code, 6'b000011);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (!key_valid || key_code !== 6'b000011 || row_drive !== 8'hFE) bad++;
    end
    check("bp_hold_errs", bad, 0);
    key_ready = 1'b1;
    step();
    check("bp_accept_valid", key_valid, 1'b0);
    check("bp_resume_row", row_drive, 8'hFD);
    keys[0][3] = 1'b0;
    wait_event(200, got);
    check("bp_rel_dir", key_pressed, 1'b0);
    step();

    // Reset while an event is held and another is pending.
    key_ready = 1'b0;
    keys[5][1] = 1'b1; keys[5][4] = 1'b1;
    wait_event(200, got);
    check("rst_pre_code", key_code, 6'b101001);
    reset = 1'b1;
    keys = '0;
    step();
    check("rst_valid", key_valid, 1'b0);
    check("rst_code", key_code, 6'd0);
    check("rst_dir", key_pressed, 1'b0);
    check("rst_map", key_map, 64'd0);
    check("rst_row", row_drive, 8'hFE);
    step();
    reset = 1'b0;
    key_ready = 1'b1;
    run_cycles(160, seen);
    check("rst_no_stale", seen, 0);
    check("rst_map_after", key_map, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans an 8x8 active-low key matrix and reports debounced press/release events to game logic through a valid/ready handshake. It drives one row low at a time, samples the column return lines, and debounces each row across repeated scans. It is the input-side counterpart of the LED matrix row-scan driver: that block strobes rows to write pixels, while this block strobes rows to read keys.

## Interface
- SETTLE_CYCLES, 4: cycles a row is held before sampling; legal range 3..15 (covers the 2-flop synchronizer).
- DEBOUNCE_SCANS, 3: consecutive identical samples of a row required before it is accepted; legal range 1..7.
- clock  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- col_sense  in  8  raw column returns, active-low (0 = key closed on the driven row); asynchronous to clock.
- row_drive  out  8  one-cold row strobe; bit r = 0 drives row r.
- key_valid  out  1  event slot full.
- key_ready  in  1  consumer accepts the event on a cycle where key_valid & key_ready.
- key_code  out  6  {row[2:0], col[2:0]} of the event.
- key_pressed  out  1  1 = press, 0 = release.
- key_map  out  8x8  debounced state; key_map[r][c] = 1 means pressed.

## Operation
- col_sense passes through a 2-flop synchronizer and is then inverted, so sample bit = 1 means pressed.
- Each row r has its own debounce state: cand[r] (8 bits) and cnt[r] (3 bits, saturating at DEBOUNCE_SCANS).
- FSM states are SETTLE, SAMPLE and EMIT.
- SETTLE:
  - settle counter runs 0..SETTLE_CYCLES-1.
  - on the last count the FSM goes to SAMPLE.
- SAMPLE (1 cycle):
  - if sample == cand[r], cnt[r]++ (saturating); otherwise cand[r] <= sample and cnt[r] <= 1.
  - pending = cand' ^ key_map[r] when cnt' == DEBOUNCE_SCANS; otherwise pending = 0.
  - pending != 0: go to EMIT.
  - pending == 0: advance the row and go to SETTLE.
- EMIT:
  - selects the lowest set pending bit c.
  - if the slot is free (key_valid == 0, or key_valid & key_ready this cycle), it loads key_code = {r, c} and key_pressed = cand[r][c], toggles key_map[r][c], and clears pending[c].
  - events are emitted at most one per cycle.
  - once pending is empty, the row advances and the FSM returns to SETTLE.
- Row advance: r wraps 7 -> 0, and row_drive = ~(8'b1 << r).
- Backpressure: while the slot is full and key_ready = 0, the FSM holds in EMIT, row_drive stays on row r, and scanning stalls. No event is ever dropped.
- key_code and key_pressed are stable while key_valid = 1.

## Timing
- Reset values:
  - row_drive = 8'b11111110 (row 0), FSM in SETTLE, settle counter 0.
  - key_valid = 0, key_code = 0, key_pressed = 0, key_map = all 0.
  - every cand = 0, every cnt = 0; both synchronizer stages = 8'hFF (released).
- Scan period with no events: 8*(SETTLE_CYCLES+1) cycles, i.e. 40 at the defaults.
- Input to sample latency: the sample reflects col_sense as of 2 cycles before SAMPLE.
- Event latency: key_valid rises 2 cycles after the SAMPLE in which cnt reaches DEBOUNCE_SCANS. This is because EMIT is entered 1 cycle after SAMPLE and the slot registers 1 cycle later.
- key_map[r][c] changes in the same cycle key_valid rises for that event.
- A back-to-back accept (valid & ready with another pending bit) reloads the slot in the same cycle, so key_valid stays high.
- Reset asserted mid-EMIT or mid-handshake: all state returns to its reset values on the next edge, and any pending and unconsumed events are discarded.

## Structure
- Package keypad_pkg holds:
  - scan_state_t enum {SETTLE, SAMPLE, EMIT}.
  - key_event_t packed struct {logic [2:0] row; logic [2:0] col; logic pressed;}.
  - localparams ROWS = 8 and COLS = 8.
- One sub-module, row_debounce: holds cand/cnt for all 8 rows, takes the row index and sample, and returns the accept flag and the accepted vector.
- The FSM, row counter and event slot live in keypad_scanner.

## Test plan
- Reset:
  - stimulus: reset asserted, then released with all keys open.
  - required: row_drive = 8'b11111110 and key_valid = 0 during reset; row_drive steps through all 8 rows, 5 cycles each, with no event.
- Clean press and release:
  - stimulus: hold key (2,5) closed for 4 scans with key_ready = 1, then open it.
  - required: exactly one event with key_code = 6'b010101 and key_pressed = 1 on the 3rd row-2 SAMPLE; key_map[2][5] = 1; after the release, one event with key_pressed = 0 and key_map[2][5] = 0.
- Bounce rejection:
  - stimulus: key (4,1) closed for 2 scans, open for 1, closed for 2, then opened.
  - required: no event and key_map unchanged.
- Multi-key same row:
  - stimulus: keys (6,7) and (6,0) close simultaneously and stay closed.
  - required: two consecutive events, col 0 first then col 7, with row_drive held at row 6 until both are emitted.
- Backpressure:
  - stimulus: key_ready = 0 for 100 cycles after a press on (0,3).
  - required: key_valid stays high with code 6'b000011; row_drive stays 8'b11111110; when ready rises, the event is accepted and the scan resumes at row 1.
- Reset mid-EMIT:
  - stimulus: assert reset while key_valid = 1 and a second pending bit exists.
  - required: all outputs return to their reset values next cycle, and no stale event appears afterwards.
